uart_rx_fifo: RTL

Serial receive front end for the memory-mapped UART peripheral. It samples the asynchronous RX pin, deserialises 8N1 frames, and buffers received bytes in a first-word-fall-through FIFO. The memory decoder reads that FIFO through the data register at 0x4001, which pops it, and the status register at 0x4002, which reports empty.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 434;
  localparam int unsigned UART_FIFO_DEPTH   = 16;
  localparam int unsigned DATA_BITS         = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through byte FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [AW:0]          count_o,
  output logic [DATA_BITS-1:0] data_o
);

  localparam int unsigned   DEPTH_V  = DEPTH;
  localparam logic [AW:0]   FULL_CNT = DEPTH_V[AW:0];

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a FWFT byte FIFO, popped on rising edges of i_Read_EN.
// Define UART_RX_OVERRUN_EN to build the sticky o_Overrun flag; otherwise it is tied low.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH
) (
  input  logic       i_CLK,
  input  logic       i_RESET_n,
  input  logic       i_RX,
  input  logic       i_Read_EN,
  output logic       o_UART_Empty,
  output logic [7:0] o_Data,
  output logic       o_Overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_meta_q, rx_sync_q;
  logic                 read_q;
  logic                 push, pop_edge;
  logic                 fifo_full;
  logic [AW:0]          fifo_count;
  logic                 unused_status;

  assign pop_edge      = i_Read_EN & ~read_q;
  assign unused_status = ^{fifo_full, fifo_count};

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      read_q    <= 1'b0;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= i_RX;
      rx_sync_q <= rx_meta_q;
      read_q    <= i_Read_EN;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT) state_d = STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        // Leave at the stop sample so the next start edge is seen with half a bit of margin.
        if (baud_q == BIT_LAST) begin
          push    = rx_sync_q;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  uart_sync_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (i_CLK),
    .rst_ni (i_RESET_n),
    .push_i (push),
    .pop_i  (pop_edge),
    .data_i (shift_q),
    .full_o (fifo_full),
    .empty_o(o_UART_Empty),
    .count_o(fifo_count),
    .data_o (o_Data)
  );

`ifdef UART_RX_OVERRUN_EN
  logic ovr_q;

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n)                 ovr_q <= 1'b0;
    else if (pop_edge)              ovr_q <= 1'b0;
    else if (push && fifo_full)     ovr_q <= 1'b1;
  end

  assign o_Overrun = ovr_q;
`else
  assign o_Overrun = 1'b0;
`endif

endmodule
